// File: rtl/lock_ctrl.sv
// lock_ctrl: BCD keypad lock with code entry, code change, fail counting and timed lockout
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   key_valid    - strobe qualifying key_digit (BCD 0-9 accepted)
//   key_digit    - keypad digit
//   key_enter    - submit entry; in OPEN relocks or stores the new code
//   key_clear    - discard the current entry
//   set_mode     - level; in OPEN, key_enter stores the code instead of relocking
//   digit_out    - last accepted digit
//   status_out   - {alarm, state[2:0]}
//   unlocked     - high in OPEN
//   alarm        - high in LOCKOUT
module lock_ctrl #(
  parameter int CODE_LEN = 4,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       set_mode,
  output logic [3:0] digit_out,
  output logic [3:0] status_out,
  output logic       unlocked,
  output logic       alarm
);
  localparam int BW = CODE_LEN * 4;
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int FW = ($clog2(MAX_FAIL + 1) > 2) ? $clog2(MAX_FAIL + 1) : 2;
  localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CODE_LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
  localparam logic [FW-1:0] FAIL_ONE = FW'(1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;
  state_t state, state_n;
  logic [BW-1:0] buffer, buffer_n, code, code_n;
  logic [BW+3:0] shifted;
  logic [CW-1:0] count, count_n;
  logic [3:0] digit_n;
  logic [FW-1:0] fail_cnt, fail_n, fail_inc;
  logic [TW-1:0] timer, timer_n;
  logic accept, match;
  assign unlocked = (state == OPEN);
  assign alarm = (state == LOCKOUT);
  assign status_out = {alarm, state};
  always_comb begin
    state_n = state;
    buffer_n = buffer;
    code_n = code;
    count_n = count;
    digit_n = digit_out;
    fail_n = fail_cnt;
    timer_n = timer;
    shifted = {buffer, key_digit};
    // saturated entries drop further digits without shifting
    accept = key_valid && (key_digit <= 4'd9) && (count != CNT_MAX);
    match = (count == CNT_MAX) && (buffer == code);
    fail_inc = fail_cnt + FAIL_ONE;
    case (state)
      IDLE, ENTRY, OPEN: begin
        if (key_clear) begin
          buffer_n = '0;
          count_n = '0;
          digit_n = '0;
          state_n = (state == OPEN) ? OPEN : IDLE;
        end else if (key_enter) begin
          if (state == ENTRY) begin
            state_n = CHECK;
          end else if (state == OPEN && !set_mode) begin
            buffer_n = '0;
            count_n = '0;
            state_n = IDLE;
          end else if (state == OPEN && count == CNT_MAX) begin
            code_n = buffer;
            buffer_n = '0;
            count_n = '0;
          end
        end else if (accept) begin
          buffer_n = shifted[BW-1:0];
          count_n = count + CNT_ONE;
          digit_n = key_digit;
          state_n = (state == OPEN) ? OPEN : ENTRY;
        end
      end
      CHECK: begin
        buffer_n = '0;
        count_n = '0;
        state_n = match ? OPEN : FAIL;
        fail_n = match ? '0 : fail_cnt;
      end
      FAIL: begin
        fail_n = fail_inc;
        state_n = (fail_inc >= FAIL_MAX) ? LOCKOUT : IDLE;
        timer_n = (fail_inc >= FAIL_MAX) ? TMR_LOAD : timer;
      end
      LOCKOUT: begin
        state_n = (timer == '0) ? IDLE : LOCKOUT;
        fail_n = (timer == '0) ? '0 : fail_cnt;
        timer_n = (timer == '0) ? timer : timer - TMR_ONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      buffer <= '0;
      code <= DEFAULT_CODE;
      count <= '0;
      digit_out <= '0;
      fail_cnt <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      buffer <= buffer_n;
      code <= code_n;
      count <= count_n;
      digit_out <= digit_n;
      fail_cnt <= fail_n;
      timer <= timer_n;
    end
  end
endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: vector table, corner sequences and random stimulus against a queue-based lock model
module tb_lock_ctrl;
  localparam int CODE_LEN = 4;
  localparam int MAX_FAIL = 3;
  localparam int LOCKOUT_CYC = 16;
  logic clk = 0;
  logic rst_n = 0;
  logic key_valid = 0;
  logic [3:0] key_digit = 0;
  logic key_enter = 0;
  logic key_clear = 0;
  logic set_mode = 0;
  logic [3:0] digit_out, status_out;
  logic unlocked, alarm;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lock_ctrl #(
    .CODE_LEN(CODE_LEN),
    .MAX_FAIL(MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_digit(key_digit),
    .key_enter(key_enter),
    .key_clear(key_clear),
    .set_mode(set_mode),
    .digit_out(digit_out),
    .status_out(status_out),
    .unlocked(unlocked),
    .alarm(alarm)
  );
  typedef struct {
    logic kv;
    logic [3:0] kd;
    logic ke;
    logic kc;
    logic sm;
    logic [3:0] es;
    logic [3:0] ed;
  } vec_t;
  vec_t vecs[$];
  int m_phase, m_last, m_fails, m_left;
  int m_entry[$];
  int m_code[$];
  function automatic void add(logic kv, logic [3:0] kd, logic ke, logic kc, logic sm,
                              logic [3:0] es, logic [3:0] ed);
    vec_t v;
    v.kv = kv; v.kd = kd; v.ke = ke; v.kc = kc; v.sm = sm; v.es = es; v.ed = ed;
    vecs.push_back(v);
  endfunction
  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_reset();
    m_phase = 0;
    m_last = 0;
    m_fails = 0;
    m_left = 0;
    m_entry.delete();
    m_code.delete();
    for (int i = 1; i <= 4; i++) m_code.push_back(i);
  endfunction
  function automatic bit entry_is_code();
    if (m_entry.size() != m_code.size()) return 0;
    foreach (m_entry[i]) if (m_entry[i] != m_code[i]) return 0;
    return 1;
  endfunction
  // Phases: 0 idle, 1 entry, 2 check, 3 open, 4 fail, 5 lockout
  function automatic void model_step(logic kv, logic [3:0] kd, logic ke, logic kc, logic sm);
    if (m_phase == 0 || m_phase == 1 || m_phase == 3) begin
      if (kc) begin
        m_entry.delete();
        m_last = 0;
        if (m_phase == 1) m_phase = 0;
      end else if (ke) begin
        if (m_phase == 1) m_phase = 2;
        else if (m_phase == 3 && !sm) begin
          m_entry.delete();
          m_phase = 0;
        end else if (m_phase == 3 && m_entry.size() == CODE_LEN) begin
          m_code = m_entry;
          m_entry.delete();
        end
      end else if (kv && kd <= 9 && m_entry.size() < CODE_LEN) begin
        m_entry.push_back(int'(kd));
        m_last = int'(kd);
        if (m_phase == 0) m_phase = 1;
      end
    end else if (m_phase == 2) begin
      if (entry_is_code()) begin
        m_phase = 3;
        m_fails = 0;
      end else m_phase = 4;
      m_entry.delete();
    end else if (m_phase == 4) begin
      m_fails++;
      if (m_fails >= MAX_FAIL) begin
        m_phase = 5;
        m_left = LOCKOUT_CYC;
      end else m_phase = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_phase = 0;
        m_fails = 0;
      end
    end
  endfunction
  task automatic cycle(logic kv, logic [3:0] kd, logic ke, logic kc, logic sm);
    key_valid = kv;
    key_digit = kd;
    key_enter = ke;
    key_clear = kc;
    set_mode = sm;
    @(posedge clk);
    model_step(kv, kd, ke, kc, sm);
    #1;
    key_valid = 0;
    key_enter = 0;
    key_clear = 0;
    check("model_status", int'(status_out), (m_phase == 5 ? 8 : 0) + m_phase);
    check("model_digit", int'(digit_out), m_last);
    check("model_unlocked", int'(unlocked), int'(m_phase == 3));
    check("model_alarm", int'(alarm), int'(m_phase == 5));
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1;
    check("async_rst_status", int'(status_out), 0);
    check("async_rst_digit", int'(digit_out), 0);
    check("async_rst_unlocked", int'(unlocked), 0);
    check("async_rst_alarm", int'(alarm), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  task automatic attempt(logic [15:0] c, logic sm);
    for (int i = 3; i >= 0; i--) cycle(1, c[i*4 +: 4], 0, 0, sm);
    cycle(0, 0, 1, 0, sm);
  endtask
  initial begin
    model_reset();
    add(1, 1, 0, 0, 0, 1, 1); add(1, 2, 0, 0, 0, 1, 2); add(1, 3, 0, 0, 0, 1, 3); add(1, 4, 0, 0, 0, 1, 4);
    add(0, 0, 1, 0, 0, 2, 4); add(0, 0, 0, 0, 0, 3, 4); add(0, 0, 1, 0, 0, 0, 4);
    add(1, 1, 0, 0, 0, 1, 1); add(1, 2, 0, 0, 0, 1, 2); add(1, 3, 0, 0, 0, 1, 3);
    add(0, 0, 1, 0, 0, 2, 3); add(0, 0, 0, 0, 0, 4, 3); add(0, 0, 0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 1, 1); add(1, 2, 0, 0, 0, 1, 2); add(1, 3, 0, 0, 0, 1, 3); add(1, 4, 0, 0, 0, 1, 4);
    add(1, 9, 0, 0, 0, 1, 4); add(1, 4'hA, 0, 0, 0, 1, 4);
    add(0, 0, 1, 0, 0, 2, 4); add(0, 0, 0, 0, 0, 3, 4);
    add(1, 9, 0, 0, 1, 3, 9); add(1, 8, 0, 0, 1, 3, 8); add(1, 7, 0, 0, 1, 3, 7); add(1, 6, 0, 0, 1, 3, 6);
    add(0, 0, 1, 0, 1, 3, 6); add(0, 0, 1, 0, 0, 0, 6);
    add(1, 1, 0, 0, 0, 1, 1); add(1, 2, 0, 0, 0, 1, 2); add(1, 3, 0, 0, 0, 1, 3); add(1, 4, 0, 0, 0, 1, 4);
    add(0, 0, 1, 0, 0, 2, 4); add(0, 0, 0, 0, 0, 4, 4); add(0, 0, 0, 0, 0, 0, 4);
    add(1, 9, 0, 0, 0, 1, 9); add(1, 8, 0, 0, 0, 1, 8); add(1, 7, 0, 0, 0, 1, 7); add(1, 6, 0, 0, 0, 1, 6);
    add(0, 0, 1, 0, 0, 2, 6); add(0, 0, 0, 0, 0, 3, 6);
    add(1, 5, 0, 0, 1, 3, 5); add(0, 0, 1, 0, 1, 3, 5); add(0, 0, 0, 1, 0, 3, 0); add(0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1, 1); add(1, 2, 0, 0, 0, 1, 2); add(1, 3, 1, 1, 0, 0, 0);
    add(1, 7, 0, 0, 0, 1, 7); add(1, 5, 1, 0, 0, 2, 7); add(0, 0, 0, 0, 0, 4, 7); add(0, 0, 0, 0, 0, 0, 7);
    add(0, 0, 1, 0, 0, 0, 7); add(0, 0, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_status", int'(status_out), 0);
    check("reset_digit", int'(digit_out), 0);
    check("reset_unlocked", int'(unlocked), 0);
    check("reset_alarm", int'(alarm), 0);
    rst_n = 1;
    foreach (vecs[i]) begin
      cycle(vecs[i].kv, vecs[i].kd, vecs[i].ke, vecs[i].kc, vecs[i].sm);
      check($sformatf("vec%0d_status", i), int'(status_out), int'(vecs[i].es));
      check($sformatf("vec%0d_digit", i), int'(digit_out), int'(vecs[i].ed));
      check($sformatf("vec%0d_unlocked", i), int'(unlocked), int'(vecs[i].es == 4'h3));
    end
    do_reset();
    for (int a = 0; a < 3; a++) begin
      attempt(16'h1235, 0);
      check("lk_check", int'(status_out), 2);
      cycle(0, 0, 0, 0, 0);
      check("lk_fail", int'(status_out), 4);
      if (a < 2) begin
        cycle(0, 0, 0, 0, 0);
        check("lk_idle", int'(status_out), 0);
      end
    end
    cycle(0, 0, 0, 0, 0);
    begin
      int n = 0;
      while (status_out == 4'hD && n < 40) begin
        n++;
        cycle(1, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
      check("alarm_cycles", n, LOCKOUT_CYC);
    end
    check("post_lockout_status", int'(status_out), 0);
    check("post_lockout_digit", int'(digit_out), 5);
    for (int a = 0; a < 3; a++) begin
      attempt(16'h4321, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
    end
    repeat (3) cycle(0, 0, 0, 0, 0);
    check("pre_rst_alarm", int'(alarm), 1);
    do_reset();
    attempt(16'h1234, 0);
    cycle(0, 0, 0, 0, 0);
    check("open_after_rst", int'(status_out), 3);
    attempt(16'h5678, 1);
    check("code_change_open", int'(status_out), 3);
    do_reset();
    attempt(16'h1234, 0);
    cycle(0, 0, 0, 0, 0);
    check("default_restored", int'(status_out), 3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle($urandom_range(0, 9) < 7,
                 ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)),
                 $urandom_range(0, 9) < 2,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
